// File: rtl/rv6_pkg.sv
// ============================================================================
// Module      : rv6_pkg
// Description : Shared front-end constants, state encodings and RVC helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv6_pkg;

  localparam int XLEN        = 64;
  localparam int FETCH_W     = 64;
  localparam int HW_PER_LINE = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  // Fetch-line request FSM: idle, or one request outstanding.
  typedef enum logic [0:0] {
    REQ_IDLE = 1'b0,
    REQ_BUSY = 1'b1
  } req_state_t;

  // A halfword starts a compressed instruction unless its low two bits are 11.
  function automatic logic is_rvc(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hw_fifo.sv
// ============================================================================
// Module      : hw_fifo
// Description : Circular halfword buffer with 0-4 entry push, 0-2 entry pop,
//               head/head+1 read-out and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hw_fifo
  import rv6_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic [2:0]               i_push_n,
  input  logic [FETCH_W-1:0]       i_push_data,
  input  logic [1:0]               i_pop_n,
  output logic [15:0]              o_h0,
  output logic [15:0]              o_h1,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [15:0]   r_ram [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic [AW-1:0] w_head1;

  assign w_head1 = r_head + 1'b1;
  assign o_h0    = r_ram[r_head];
  assign o_h1    = r_ram[w_head1];
  assign o_count = r_count;

  // Store the first i_push_n halfwords of the (pre-shifted) line at tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ram[i] <= '0;
      end
    end else if (!i_clr) begin
      for (int k = 0; k < HW_PER_LINE; k++) begin
        if (3'(k) < i_push_n) begin
          r_ram[r_tail + AW'(k)] <= i_push_data[16*k +: 16];
        end
      end
    end
  end

  // Pointer and occupancy bookkeeping; a clear empties the buffer outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(i_pop_n);
      r_tail  <= r_tail + AW'(i_push_n);
      r_count <= r_count + (AW+1)'(i_push_n) - (AW+1)'(i_pop_n);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ia.sv
// ============================================================================
// Module      : ia
// Description : Instruction aligner. Buffers fetch lines as halfwords and
//               presents one 16- or 32-bit raw instruction per cycle with
//               its PC; handles line-straddling instructions and redirects.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ia
  import rv6_pkg::*;
#(
  parameter int              BUF_HW   = 8,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                fetch_req,
  output logic [XLEN-1:0]     fetch_addr,
  input  logic                fetch_ack,
  input  logic [FETCH_W-1:0]  fetch_data,
  input  logic                flush,
  input  logic [XLEN-1:0]     flush_pc,
  input  logic                stall,
  output logic [XLEN-1:0]     pc_out,
  output logic [31:0]         ir_out,
  output logic                ir_vld
);

  localparam int          AW        = $clog2(BUF_HW);
  localparam logic [AW:0] REQ_LIMIT = (AW+1)'(BUF_HW - HW_PER_LINE);

  req_state_t       r_state;
  req_state_t       w_state_nxt;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_fetch_addr;
  logic [XLEN-1:0]  r_pend_addr;
  logic [1:0]       r_skip;
  logic             r_drop;

  logic [15:0]      w_h0;
  logic [15:0]      w_h1;
  logic [AW:0]      w_count;
  logic             w_need2;
  logic [AW:0]      w_need;
  logic             w_pop;
  logic [1:0]       w_pop_n;
  logic             w_push;
  logic [2:0]       w_push_n;
  logic [FETCH_W-1:0] w_push_data;
  logic [XLEN-1:0]  w_flush_line;

  hw_fifo #(
    .DEPTH (BUF_HW)
  ) u_hw_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (flush),
    .i_push_n    (w_push_n),
    .i_push_data (w_push_data),
    .i_pop_n     (w_pop_n),
    .o_h0        (w_h0),
    .o_h1        (w_h1),
    .o_count     (w_count)
  );

  // Head decode: length from the first halfword, valid once enough are buffered.
  assign w_need2 = !is_rvc(w_h0);
  assign w_need  = w_need2 ? (AW+1)'(2) : (AW+1)'(1);
  assign ir_vld  = (w_count >= w_need) && !flush;
  assign ir_out  = w_need2 ? {w_h1, w_h0} : {16'b0, w_h0};
  assign pc_out  = r_pc;

  assign w_pop   = ir_vld && !stall;
  assign w_pop_n = !w_pop ? 2'd0 : (w_need2 ? 2'd2 : 2'd1);

  // Leading halfwords before a redirect target are shifted out of the line.
  assign w_push      = fetch_ack && !r_drop && !flush;
  assign w_push_n    = w_push ? (3'd4 - {1'b0, r_skip}) : 3'd0;
  assign w_push_data = fetch_data >> {r_skip, 4'b0000};

  assign w_flush_line = {flush_pc[XLEN-1:3], 3'b000};
  assign fetch_req    = (r_state == REQ_BUSY);
  assign fetch_addr   = r_fetch_addr;

  // Request state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= REQ_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next request state. In IDLE nothing is in flight, so the count alone
  // decides whether a whole line still fits. A redirect empties the buffer
  // and launches the new line at once unless an old request is still owed.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      REQ_IDLE: begin
        if (flush || (w_count <= REQ_LIMIT)) begin
          w_state_nxt = REQ_BUSY;
        end
      end
      REQ_BUSY: begin
        if (fetch_ack) begin
          w_state_nxt = flush ? REQ_BUSY : REQ_IDLE;
        end
      end
      default: w_state_nxt = REQ_IDLE;
    endcase
  end

  // PC, line address, skip and drop tracking; redirect takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_fetch_addr <= {RESET_PC[XLEN-1:3], 3'b000};
      r_pend_addr  <= {RESET_PC[XLEN-1:3], 3'b000};
      r_skip       <= RESET_PC[2:1];
      r_drop       <= 1'b0;
    end else if (flush) begin
      r_pc   <= flush_pc & ~XLEN'(1);
      r_skip <= flush_pc[2:1];
      if (fetch_req && !fetch_ack) begin
        // Old request still owed: keep its address stable, retarget later.
        r_drop      <= 1'b1;
        r_pend_addr <= w_flush_line;
      end else begin
        r_drop       <= 1'b0;
        r_fetch_addr <= w_flush_line;
      end
    end else begin
      if (w_pop) begin
        r_pc <= r_pc + XLEN'({w_pop_n, 1'b0});
      end
      if (fetch_ack) begin
        if (r_drop) begin
          r_drop       <= 1'b0;
          r_fetch_addr <= r_pend_addr;
        end else begin
          r_fetch_addr <= r_fetch_addr + XLEN'(8);
          r_skip       <= 2'd0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ia.sv
// ============================================================================
// Module      : tb_ia
// Description : Scoreboard bench for the instruction aligner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ia;
  import rv6_pkg::*;

  localparam logic [63:0] RPC     = 64'h0000_0000_8000_0000;
  localparam int          MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [63:0] fetch_addr;
  logic        fetch_ack;
  logic [63:0] fetch_data;
  logic        flush;
  logic [63:0] flush_pc;
  logic        stall;
  logic [63:0] pc_out;
  logic [31:0] ir_out;
  logic        ir_vld;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc    = 0;
  int          first_ack = -1;
  int          first_vld = -1;
  int          mem_allow = -1;
  logic        stall_force = 1'b0;
  logic [63:0] exp_pc [$];
  logic [31:0] exp_ir [$];

  ia #(
    .BUF_HW   (8),
    .RESET_PC (RPC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ack  (fetch_ack),
    .fetch_data (fetch_data),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .stall      (stall),
    .pc_out     (pc_out),
    .ir_out     (ir_out),
    .ir_vld     (ir_vld)
  );

  always #5 clk = ~clk;

  // Address-derived compressed filler used for every line not listed below.
  function automatic logic [15:0] dflt_hw(input logic [63:0] a);
    return {4'h1, a[9:3], a[2:1], 3'b001};
  endfunction

  function automatic logic [63:0] line_at(input logic [63:0] la);
    case (la)
      64'h8000_0000: return 64'h0000_0013_0000_0413;
      64'h8000_0008: return 64'h0001_8082_0505_4501;
      64'h8000_0010: return 64'h8533_4681_4601_4581;
      64'h8000_0018: return 64'h0001_0001_0001_00C5;
      default:       return {dflt_hw(la + 64'd6), dflt_hw(la + 64'd4),
                             dflt_hw(la + 64'd2), dflt_hw(la)};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [63:0] pc, input logic [31:0] ir);
    exp_pc.push_back(pc);
    exp_ir.push_back(ir);
  endtask

  task automatic push_dflt(input logic [63:0] pc0, input int n);
    for (int i = 0; i < n; i++) begin
      push_exp(pc0 + 64'(2 * i), {16'b0, dflt_hw(pc0 + 64'(2 * i))});
    end
  endtask

  task automatic drain(input string nm);
    int i;
    i = 0;
    while (exp_pc.size() != 0 && i < 300) begin
      tick(1);
      i++;
    end
    chk(nm, 64'(exp_pc.size()), 64'd0);
  endtask

  // Fetch-port model: acks MEM_LAT cycles into a request, budget-limited.
  initial begin
    int wait_cnt;
    wait_cnt   = 0;
    fetch_ack  = 1'b0;
    fetch_data = '0;
    forever begin
      @(posedge clk);
      #1;
      fetch_ack = 1'b0;
      if (rst_n && fetch_req && mem_allow != 0) begin
        if (wait_cnt >= MEM_LAT - 1) begin
          fetch_ack  = 1'b1;
          fetch_data = line_at(fetch_addr);
          wait_cnt   = 0;
          if (mem_allow > 0) mem_allow--;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Downstream holds off whenever nothing more is expected.
  initial begin
    stall = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      stall = stall_force || (exp_pc.size() == 0);
    end
  end

  // Monitor: every consumed instruction is matched against the scoreboard.
  initial begin
    logic [63:0] p;
    logic [31:0] ir;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (fetch_ack && first_ack < 0) first_ack = cyc;
        if (ir_vld && first_vld < 0) first_vld = cyc;
        if (ir_vld && !stall) begin
          if (exp_pc.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_instr: got pc %h ir %h, expected none", pc_out, ir_out);
          end else begin
            p  = exp_pc.pop_front();
            ir = exp_ir.pop_front();
            chk("pc_out", pc_out, p);
            chk("ir_out", {32'b0, ir_out}, {32'b0, ir});
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    flush_pc    = '0;
    mem_allow   = 3;
    tick(3);
    chk("rst_ir_vld",     64'(ir_vld),    64'd0);
    chk("rst_ir_out",     64'(ir_out),    64'd0);
    chk("rst_pc_out",     pc_out,         RPC);
    chk("rst_fetch_req",  64'(fetch_req), 64'd0);
    chk("rst_fetch_addr", fetch_addr,     RPC);

    // Straight-line program: 32-bit, compressed, and a line-straddling add.
    push_exp(64'h8000_0000, 32'h0000_0413);
    push_exp(64'h8000_0004, 32'h0000_0013);
    push_exp(64'h8000_0008, 32'h0000_4501);
    push_exp(64'h8000_000A, 32'h0000_0505);
    push_exp(64'h8000_000C, 32'h0000_8082);
    push_exp(64'h8000_000E, 32'h0000_0001);
    push_exp(64'h8000_0010, 32'h0000_4581);
    push_exp(64'h8000_0012, 32'h0000_4601);
    push_exp(64'h8000_0014, 32'h0000_4681);
    push_exp(64'h8000_0016, 32'h00C5_8533);
    push_exp(64'h8000_001A, 32'h0000_0001);
    push_exp(64'h8000_001C, 32'h0000_0001);
    push_exp(64'h8000_001E, 32'h0000_0001);
    @(negedge clk);
    rst_n = 1'b1;

    // Only three lines are served, so the split instruction must wait.
    for (int i = 0; i < 100 && pc_out != 64'h8000_0016; i++) tick(1);
    tick(3);
    chk("split_hold_pc",  pc_out,               64'h8000_0016);
    chk("split_hold_vld", 64'(ir_vld),          64'd0);
    chk("split_hold_lo",  64'(ir_out[15:0]),    64'h8533);
    mem_allow = -1;
    drain("drain_program");
    chk("first_vld_after_ack", 64'(first_vld), 64'(first_ack + 1));

    // Stall with the buffer full: head must not move, no new request.
    stall_force = 1'b1;
    tick(20);
    repeat (5) begin
      tick(1);
      chk("stall_pc_out",    pc_out,            64'h8000_0020);
      chk("stall_ir_out",    64'(ir_out),       {48'b0, dflt_hw(64'h8000_0020)});
      chk("stall_ir_vld",    64'(ir_vld),       64'd1);
      chk("stall_fetch_req", 64'(fetch_req),    64'd0);
    end
    push_dflt(64'h8000_0020, 12);
    stall_force = 1'b0;
    drain("drain_after_stall");

    // Redirect with no request outstanding into the middle of a line.
    tick(10);
    chk("idle_before_flush", 64'(fetch_req), 64'd0);
    flush_pc = 64'h8000_1006;
    flush    = 1'b1;
    push_dflt(64'h8000_1006, 4);
    tick(1);
    flush = 1'b0;
    chk("flush_fetch_addr", fetch_addr,      64'h8000_1000);
    chk("flush_fetch_req",  64'(fetch_req),  64'd1);
    drain("drain_flush");

    // Asynchronous reset in the middle of operation.
    tick(2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ir_vld",     64'(ir_vld),    64'd0);
    chk("midrst_pc_out",     pc_out,         RPC);
    chk("midrst_fetch_req",  64'(fetch_req), 64'd0);
    chk("midrst_fetch_addr", fetch_addr,     RPC);
    mem_allow = 1;
    tick(2);
    push_exp(64'h8000_0000, 32'h0000_0413);
    push_exp(64'h8000_0004, 32'h0000_0013);
    @(negedge clk);
    rst_n = 1'b1;

    // Redirect while the 0x80000008 request is held unacked: it must be dropped.
    for (int i = 0; i < 100 && !(exp_pc.size() == 0 && fetch_req && fetch_addr == 64'h8000_0008); i++) tick(1);
    chk("pending_req_addr", fetch_addr, 64'h8000_0008);
    flush_pc = 64'h8000_2001;
    flush    = 1'b1;
    push_dflt(64'h8000_2000, 4);
    tick(1);
    flush = 1'b0;
    chk("drop_addr_stable", fetch_addr,     64'h8000_0008);
    chk("drop_req_held",    64'(fetch_req), 64'd1);
    mem_allow = -1;
    drain("drain_drop");

    tick(5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ia.md
# ia

Instruction aligner between the I-cache fetch port and the `pd` pre-decode stage. It buffers 64-bit fetch lines as a circular queue of 16-bit halfwords and extracts one instruction per cycle at the current PC. Each instruction is a 16-bit compressed one or a 32-bit one, including 32-bit instructions that straddle a fetch-line boundary. It presents the raw instruction and its PC to `pd`; RVC expansion happens in `pd`, not here.

## Interface
- `BUF_HW`, 8: halfword buffer depth. Power of two, ≥ 8.
- `RESET_PC`, 64'h0000_0000_8000_0000: PC after reset.
- `clk` in 1: clock.
- `rst_n` in 1: reset. Asynchronous, active-low, as already decided.
- `fetch_req` out 1: line request valid.
- `fetch_addr` out 64: 8-byte-aligned line address. Stable while `fetch_req` && !`fetch_ack`.
- `fetch_ack` in 1: `fetch_data` valid this cycle. Completes the request.
- `fetch_data` in 64: line data, halfword 0 in bits [15:0].
- `flush` in 1: redirect.
- `flush_pc` in 64: redirect target. Bit 0 is ignored.
- `stall` in 1: downstream stall. No instruction is consumed while it is high.
- `pc_out` out 64: PC of the instruction at the head.
- `ir_out` out 32: raw instruction. Compressed instructions are zero-extended to `{16'b0, hw}`.
- `ir_vld` out 1: `pc_out`/`ir_out` are valid.

## Operation
- State:
  - Halfword RAM `BUF_HW`×16 with `head`/`tail` pointers, log2(`BUF_HW`) bits, wrapping modulo `BUF_HW`.
  - `count` (0..`BUF_HW`).
  - `pc`, `fetch_addr`.
  - `fetch_req` register.
  - `skip` (2 bits): halfwords to discard from the next accepted line.
  - `drop` flag.
- Reset values:
  - `pc`=`RESET_PC`, `fetch_addr`={`RESET_PC`[63:3],3'b0}, `skip`=`RESET_PC`[2:1].
  - `fetch_req`=0, `drop`=0, `count`=0, `head`=`tail`=0, RAM zeroed.
  - Resulting outputs: `ir_vld`=0, `ir_out`=0, `pc_out`=`RESET_PC`.
- Request FSM, two states:
  - IDLE→REQ when `count` + pending-push ≤ `BUF_HW`−4 and !`flush`.
  - REQ→IDLE on `fetch_ack`. At that point `fetch_addr` += 8, unless the response is dropped.
  - At most one request is outstanding.
- Push on `fetch_ack` with !`drop` and !`flush`:
  - Write halfwords `skip`..3 at `tail`.
  - `tail` += 4−`skip`, `count` += 4−`skip`, then `skip`=0.
- Head decode, all combinational:
  - h0 = RAM[`head`], h1 = RAM[`head`+1].
  - need = (h0[1:0]==2'b11) ? 2 : 1.
  - `ir_vld` = (`count` ≥ need) && !`flush`.
  - `ir_out` = need==2 ? {h1,h0} : {16'b0,h0}.
  - `pc_out` = `pc`.
- Pop when `ir_vld` && !`stall`:
  - `head` += need, `count` −= need, `pc` += 2·need.
  - Push and pop in the same cycle: `count` += pushed − popped.
- Flush has priority over push, pop and request issue:
  - `count`=0, `head`=`tail`=0, `pc`=`flush_pc` with bit 0 cleared.
  - `fetch_addr`={`flush_pc`[63:3],3'b0}, `skip`=`flush_pc`[2:1].
  - If a request is pending and not acked in the flush cycle: set `drop`. `fetch_addr` keeps its old value until that ack, the ack's data is discarded, `drop` clears, and the new address loads.
  - `fetch_ack` in the flush cycle: data discarded.
- A 32-bit instruction at the last halfword of a line holds `ir_vld`=0 until the next line is pushed.
- Reset asserted mid-operation: all state returns to reset values immediately. An in-flight ack after reset release is not expected; the fetch port is reset by the same `rst_n`.

## Timing
- Pushed data is visible at the head the cycle after `fetch_ack`, with no bypass.
- Flush in cycle 0: `fetch_req`=1 in cycle 1 if no drop is pending. With ack in cycle k, the earliest `ir_vld` is k+1.
- Sustained throughput is one instruction per cycle while the buffer stays ahead. Each line supplies 2–4 instructions, so 32-bit code needs one ack every 2 cycles.
- `fetch_req` is registered. `ir_vld`, `ir_out` and `pc_out` are combinational from registers and `flush`.

## Structure
- Shared package `rv6_pkg` holds:
  - `XLEN`=64, `FETCH_W`=64, `HW_PER_LINE`=4.
  - RVC detection as the function `is_rvc(hw)` = hw[1:0]!=2'b11.
  - `RESET_PC` default.
- One sub-module, `hw_fifo`: halfword RAM with multi-entry push (1–4) and pop (1–2) plus count. The request FSM, flush/drop logic and head decode stay in `ia`.

## Test plan
- After reset with `RESET_PC`=0x80000000, line 0x00000013_00000413 acked at cycle 3 → `ir_vld` at cycle 4; `ir_out`=0x00000413 at 0x80000000, then 0x00000013 at 0x80000004.
- Line {0x4501, 0x0505, 0x8082, 0x0001} → four compressed instructions with `ir_out`=0x00004501, 0x00000505, 0x00008082, 0x00000001 at PCs +0, +2, +4, +6, one per cycle.
- Compressed at +0/+2/+4, then 32-bit 0x00C58533 split as halfword 0x8533 at +6 and halfword 0x00C5 at the next line's +0 → `ir_vld`=0 until the second line is pushed, then `ir_out`=0x00C58533, `pc_out`=base+6.
- `flush_pc`=0x80001006 with no request pending → `fetch_addr`=0x80001000; the first 3 halfwords of the acked line are dropped; first `pc_out`=0x80001006.
- Flush while a request to 0x80000008 is pending and unacked → that ack's data is discarded, then a request issues for the `flush_pc` line; no stale instruction appears on `ir_out`.
- `stall`=1 for 5 cycles with the buffer full → `pc_out`/`ir_out` are stable, `fetch_req` stays 0, and no halfword is lost once `stall` drops.
